// File: rtl/asmodee_boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : asmodee_boot_pkg
//  Description : Shared types, constants and helpers for the asmodee boot
//                sequencer (state encoding, core-control bundle, sizing).
//  Revision    : 1.0  initial release
// ============================================================================
package asmodee_boot_pkg;

   // Sequencer states; the encodings are visible on state_o
   typedef enum logic [2:0] {
      BS_HOLD   = 3'd0,
      BS_BOOT   = 3'd1,
      BS_SETTLE = 3'd2,
      BS_START  = 3'd3,
      BS_RUN    = 3'd4
   } boot_state_e;

   // Width of the saturating completed-start counter
   localparam int BOOT_CNT_W = 8;

   // Core-facing controls plus the running flag, registered as one bundle
   typedef struct packed {
      logic rst;
      logic boot;
      logic start;
      logic run;
   } core_ctrl_t;

   // Largest of the five timing parameters; sizes the shared down-counter
   function automatic int max_cycles(input int a, input int b, input int c,
                                     input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

   // Control levels the core sees while the sequencer sits in a given state
   function automatic core_ctrl_t ctrl_of(input boot_state_e s);
      core_ctrl_t c;
      c = '{rst: 1'b1, boot: 1'b0, start: 1'b0, run: 1'b0};
      case (s)
         BS_HOLD:   c = '{rst: 1'b1, boot: 1'b0, start: 1'b0, run: 1'b0};
         BS_BOOT:   c = '{rst: 1'b1, boot: 1'b1, start: 1'b0, run: 1'b0};
         BS_SETTLE: c = '{rst: 1'b0, boot: 1'b0, start: 1'b0, run: 1'b0};
         BS_START:  c = '{rst: 1'b0, boot: 1'b0, start: 1'b1, run: 1'b0};
         BS_RUN:    c = '{rst: 1'b0, boot: 1'b0, start: 1'b0, run: 1'b1};
         default:   c = '{rst: 1'b1, boot: 1'b0, start: 1'b0, run: 1'b0};
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_toggle_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_toggle_detect
//  Description : Two-flop synchroniser for an asynchronous toggle followed by
//                an edge-detect register; emits a one-cycle pulse for every
//                transition (rising or falling) of the input.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_toggle_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_async,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Metastability filter plus one delayed copy for edge comparison
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_pulse = r_sync ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/asmodee_boot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : asmodee_boot_seq
//  Description : Clocked boot sequencer for the asmodee asynchronous core.
//                Drives reset / boot-load / start in a fixed order from flops
//                only, then supervises the core through a heartbeat toggle
//                and replays the sequence on stall or software restart.
//  Revision    : 1.0  initial release
// ============================================================================
import asmodee_boot_pkg::*;

module asmodee_boot_seq #(
   parameter int RST_CYCLES    = 10,
   parameter int BOOT_CYCLES   = 5,
   parameter int SETTLE_CYCLES = 5,
   parameter int START_CYCLES  = 1,
   parameter int WDOG_CYCLES   = 1024,
   parameter bit WDOG_EN       = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  restart_i,
   input  logic                  heartbeat_i,
   output logic                  asm_rst_o,
   output logic                  asm_boot_o,
   output logic                  asm_start_o,
   output logic                  running_o,
   output logic [2:0]            state_o,
   output logic [BOOT_CNT_W-1:0] boot_count_o,
   output logic                  wdog_timeout_o
);

   localparam int CNT_W = $clog2(max_cycles(RST_CYCLES, BOOT_CYCLES, SETTLE_CYCLES,
                                            START_CYCLES, WDOG_CYCLES) + 1);

   // Counter reload values: a state lasting N cycles loads N-1 and advances at 0
   localparam logic [CNT_W-1:0] c_rst_load    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_boot_load   = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_start_load  = CNT_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_wdog_load   = CNT_W'(WDOG_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

   localparam logic [BOOT_CNT_W-1:0] c_bc_max = {BOOT_CNT_W{1'b1}};
   localparam logic [BOOT_CNT_W-1:0] c_bc_one = BOOT_CNT_W'(1);

   boot_state_e           r_state;
   logic [CNT_W-1:0]      r_cnt;
   core_ctrl_t            r_ctrl;
   logic [BOOT_CNT_W-1:0] r_boot_count;
   logic                  r_wdog_timeout;
   logic                  w_hb_pulse;

   // Heartbeat synchroniser runs in every state so no stale edge shows up on RUN entry
   sync_toggle_detect u_hb_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_async (heartbeat_i),
      .o_pulse (w_hb_pulse)
   );

   // Sequencer FSM: shared down-counter, registered core controls, watchdog
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state        <= BS_HOLD;
         r_cnt          <= c_rst_load;
         r_ctrl         <= ctrl_of(BS_HOLD);
         r_boot_count   <= '0;
         r_wdog_timeout <= 1'b0;
      end else begin
         r_wdog_timeout <= 1'b0;
         if (restart_i) begin
            // Restart overrides everything, including a coincident watchdog expiry
            r_state <= BS_HOLD;
            r_cnt   <= c_rst_load;
            r_ctrl  <= ctrl_of(BS_HOLD);
         end else begin
            case (r_state)
               BS_HOLD: begin
                  if (r_cnt == '0) begin
                     r_state <= BS_BOOT;
                     r_cnt   <= c_boot_load;
                     r_ctrl  <= ctrl_of(BS_BOOT);
                  end else begin
                     r_cnt <= r_cnt - c_cnt_one;
                  end
               end
               BS_BOOT: begin
                  if (r_cnt == '0) begin
                     r_state <= BS_SETTLE;
                     r_cnt   <= c_settle_load;
                     r_ctrl  <= ctrl_of(BS_SETTLE);
                  end else begin
                     r_cnt <= r_cnt - c_cnt_one;
                  end
               end
               BS_SETTLE: begin
                  if (r_cnt == '0) begin
                     r_state <= BS_START;
                     r_cnt   <= c_start_load;
                     r_ctrl  <= ctrl_of(BS_START);
                     if (r_boot_count != c_bc_max) begin
                        r_boot_count <= r_boot_count + c_bc_one;
                     end
                  end else begin
                     r_cnt <= r_cnt - c_cnt_one;
                  end
               end
               BS_START: begin
                  if (r_cnt == '0) begin
                     r_state <= BS_RUN;
                     r_cnt   <= c_wdog_load;
                     r_ctrl  <= ctrl_of(BS_RUN);
                  end else begin
                     r_cnt <= r_cnt - c_cnt_one;
                  end
               end
               BS_RUN: begin
                  // With the watchdog disabled the counter simply holds
                  if (WDOG_EN) begin
                     if (w_hb_pulse) begin
                        r_cnt <= c_wdog_load;
                     end else if (r_cnt == '0) begin
                        r_state        <= BS_HOLD;
                        r_cnt          <= c_rst_load;
                        r_ctrl         <= ctrl_of(BS_HOLD);
                        r_wdog_timeout <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                     end
                  end
               end
               default: begin
                  // Unreachable encodings recover through a full sequence
                  r_state <= BS_HOLD;
                  r_cnt   <= c_rst_load;
                  r_ctrl  <= ctrl_of(BS_HOLD);
               end
            endcase
         end
      end
   end

   assign asm_rst_o      = r_ctrl.rst;
   assign asm_boot_o     = r_ctrl.boot;
   assign asm_start_o    = r_ctrl.start;
   assign running_o      = r_ctrl.run;
   assign state_o        = r_state;
   assign boot_count_o   = r_boot_count;
   assign wdog_timeout_o = r_wdog_timeout;

endmodule
`default_nettype wire

// File: tb/tb_asmodee_boot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asmodee_boot_seq
//  Description : Self-checking bench for asmodee_boot_seq: directed vector
//                table for the boot timeline and restart, plus hand-written
//                sequences for heartbeat, watchdog, async reset, saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_asmodee_boot_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       restart = 1'b0;
   logic       hb = 1'b0;
   logic       a_rst, a_boot, a_start, a_run, a_wdog;
   logic [2:0] a_state;
   logic [7:0] a_bc;

   logic       rst_b = 1'b1;
   logic       restart_b = 1'b0;
   logic       hb_b = 1'b0;
   logic       b_rst, b_boot, b_start, b_run, b_wdog;
   logic [2:0] b_state;
   logic [7:0] b_bc;
   logic       c_rst, c_boot, c_start, c_run, c_wdog;
   logic [2:0] c_state;
   logic [7:0] c_bc;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   asmodee_boot_seq u_dut_a (
      .clk_i(clk), .rst_i(rst), .restart_i(restart), .heartbeat_i(hb),
      .asm_rst_o(a_rst), .asm_boot_o(a_boot), .asm_start_o(a_start),
      .running_o(a_run), .state_o(a_state), .boot_count_o(a_bc),
      .wdog_timeout_o(a_wdog)
   );

   asmodee_boot_seq #(.WDOG_CYCLES(4)) u_dut_b (
      .clk_i(clk), .rst_i(rst_b), .restart_i(restart_b), .heartbeat_i(hb_b),
      .asm_rst_o(b_rst), .asm_boot_o(b_boot), .asm_start_o(b_start),
      .running_o(b_run), .state_o(b_state), .boot_count_o(b_bc),
      .wdog_timeout_o(b_wdog)
   );

   asmodee_boot_seq #(.WDOG_CYCLES(4), .WDOG_EN(1'b0)) u_dut_c (
      .clk_i(clk), .rst_i(rst_b), .restart_i(restart_b), .heartbeat_i(hb_b),
      .asm_rst_o(c_rst), .asm_boot_o(c_boot), .asm_start_o(c_start),
      .running_o(c_run), .state_o(c_state), .boot_count_o(c_bc),
      .wdog_timeout_o(c_wdog)
   );

   typedef struct {
      int         grp;
      int         n;
      bit         restart;
      bit         e_rst;
      bit         e_boot;
      bit         e_start;
      bit         e_run;
      logic [2:0] e_state;
      logic [7:0] e_bc;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   function automatic vec_t mk(int g, int n, bit rs, bit r, bit b, bit s, bit run,
                               logic [2:0] st, logic [7:0] bc);
      vec_t v;
      v.grp = g; v.n = n; v.restart = rs;
      v.e_rst = r; v.e_boot = b; v.e_start = s; v.e_run = run;
      v.e_state = st; v.e_bc = bc;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got=%0h expected=%0h", name, edge_n, got, exp);
      end
   endtask

   // Pulse reset on DUT A; rst falls 1 ns after an edge, so the next edge is edge 1
   task automatic reset_a();
      restart = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      edge_n = 0;
   endtask

   task automatic run_group(input int g);
      reset_a();
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].grp == g) begin
            while (edge_n < vecs[i].n) begin
               restart = (edge_n == vecs[i].n - 1) ? vecs[i].restart : 1'b0;
               tick();
            end
            restart = 1'b0;
            chk($sformatf("vec%0d", i),
                {17'd0, a_rst, a_boot, a_start, a_run, a_state, a_bc, a_wdog},
                {17'd0, vecs[i].e_rst, vecs[i].e_boot, vecs[i].e_start, vecs[i].e_run,
                 vecs[i].e_state, vecs[i].e_bc, 1'b0});
         end
      end
   endtask

   task automatic advance_to(input int n);
      while (edge_n < n) tick();
   endtask

   initial begin
      bit seen_to;
      bit seen_drop;

      // Group 1: default timeline from reset release
      vecs[0]  = mk(1,  0, 0, 1, 0, 0, 0, 3'd0, 8'd0);
      vecs[1]  = mk(1,  9, 0, 1, 0, 0, 0, 3'd0, 8'd0);
      vecs[2]  = mk(1, 10, 0, 1, 1, 0, 0, 3'd1, 8'd0);
      vecs[3]  = mk(1, 14, 0, 1, 1, 0, 0, 3'd1, 8'd0);
      vecs[4]  = mk(1, 15, 0, 0, 0, 0, 0, 3'd2, 8'd0);
      vecs[5]  = mk(1, 19, 0, 0, 0, 0, 0, 3'd2, 8'd0);
      vecs[6]  = mk(1, 20, 0, 0, 0, 1, 0, 3'd3, 8'd1);
      vecs[7]  = mk(1, 21, 0, 0, 0, 0, 1, 3'd4, 8'd1);
      // Group 2: restart sampled at edge 13 while in BOOT
      vecs[8]  = mk(2,  0, 0, 1, 0, 0, 0, 3'd0, 8'd0);
      vecs[9]  = mk(2, 12, 0, 1, 1, 0, 0, 3'd1, 8'd0);
      vecs[10] = mk(2, 13, 1, 1, 0, 0, 0, 3'd0, 8'd0);
      vecs[11] = mk(2, 22, 0, 1, 0, 0, 0, 3'd0, 8'd0);
      vecs[12] = mk(2, 23, 0, 1, 1, 0, 0, 3'd1, 8'd0);
      vecs[13] = mk(2, 32, 0, 0, 0, 0, 0, 3'd2, 8'd0);
      vecs[14] = mk(2, 33, 0, 0, 0, 1, 0, 3'd3, 8'd1);
      vecs[15] = mk(2, 34, 0, 0, 0, 0, 1, 3'd4, 8'd1);

      tick();
      run_group(1);

      // Healthy heartbeat every 100 cycles keeps RUN alive
      seen_to = 1'b0;
      seen_drop = 1'b0;
      for (int i = 1; i <= 5000; i++) begin
         if (i % 100 == 0) hb = ~hb;
         tick();
         if (a_wdog) seen_to = 1'b1;
         if (!a_run) seen_drop = 1'b1;
      end
      chk("hb_no_timeout", {31'd0, seen_to}, 32'd0);
      chk("hb_running", {31'd0, seen_drop}, 32'd0);

      run_group(2);

      // Frozen heartbeat: expiry 1024 cycles after RUN entry at edge 21
      reset_a();
      advance_to(1044);
      chk("wdog_early", {31'd0, a_wdog}, 32'd0);
      tick();
      chk("wdog_expire", {28'd0, a_wdog, a_rst, a_state}, {28'd0, 1'b1, 1'b1, 3'd0});
      tick();
      chk("wdog_one_cycle", {31'd0, a_wdog}, 32'd0);
      advance_to(1055);
      chk("replay_boot", {29'd0, a_boot, a_state[1:0]}, {29'd0, 1'b1, 2'd1});
      advance_to(1065);
      chk("replay_start", {23'd0, a_start, a_bc}, {23'd0, 1'b1, 8'd2});

      // Restart coincident with expiry: HOLD entered, no timeout pulse
      reset_a();
      advance_to(1044);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rst_vs_wdog", {27'd0, a_wdog, a_rst, a_state, 1'b0}, {27'd0, 1'b0, 1'b1, 3'd0, 1'b0});
      tick();
      chk("rst_vs_wdog_next", {31'd0, a_wdog}, 32'd0);

      // Asynchronous reset mid-START
      reset_a();
      advance_to(20);
      chk("pre_async_start", {31'd0, a_start}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", {17'd0, a_rst, a_boot, a_start, a_run, a_state, a_bc, a_wdog},
          {17'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0});

      // Saturation with WDOG_CYCLES=4 (start every 25 edges), and disabled watchdog
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      seen_to = 1'b0;
      seen_drop = 1'b0;
      for (int e = 1; e <= 6400; e++) begin
         tick();
         if (c_wdog) seen_to = 1'b1;
         if (e >= 21 && !c_run) seen_drop = 1'b1;
         if (e == 20)   chk("sat_first", {23'd0, b_start, b_bc}, {23'd0, 1'b1, 8'd1});
         if (e == 25)   chk("sat_wdog", {30'd0, b_wdog, b_rst}, {30'd0, 1'b1, 1'b1});
         if (e == 6345) chk("sat_254", {24'd0, b_bc}, 32'd254);
         if (e == 6370) chk("sat_255", {24'd0, b_bc}, 32'd255);
         if (e == 6396) chk("sat_hold", {24'd0, b_bc}, 32'd255);
      end
      chk("nowdog_timeout", {31'd0, seen_to}, 32'd0);
      chk("nowdog_running", {31'd0, seen_drop}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
